// File: rtl/mux4_rr_arbiter.sv
// ----------------------------------------------------------------------------
// mux4_rr_arbiter
//
// Round-robin arbiter and sequencer in front of a shared 4:1 data mux.
// Four requesters each present a request and a WIDTH-bit word. The arbiter
// picks one requester, captures its word through the 4:1 select into an
// output register and offers it downstream on a valid/ready handshake.
// The winning requester is acked in the cycle the consumer takes the word.
//
// Build option:
//   ARB_LOCK_EN  when defined, adds the lock port. A requester holding its
//                lock bit may keep the grant for up to MAX_LOCK consecutive
//                transfers before the round-robin pointer moves on.
//
// Parameters:
//   WIDTH     data width per requester and of out_data
//   MAX_LOCK  max consecutive transfers by one locked requester (>= 1)
//
// Ports:
//   clk        clock, all state on the rising edge
//   rst        synchronous active-high reset
//   req        per-requester request
//   in_data    word i at in_data[i*WIDTH +: WIDTH]
//   lock       per-requester grant lock (ARB_LOCK_EN only)
//   out_ready  consumer accepts out_data this cycle
//   out_valid  out_data holds a granted word
//   out_data   registered captured word
//   sel        index of current/last granted requester
//   ack        one-hot, ack[sel] in the transfer cycle only
// ----------------------------------------------------------------------------
module mux4_rr_arbiter #(
   parameter int WIDTH    = 8,
   parameter int MAX_LOCK = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [3:0]         req,
   input  logic [4*WIDTH-1:0] in_data,
`ifdef ARB_LOCK_EN
   input  logic [3:0]         lock,
`endif
   input  logic               out_ready,
   output logic               out_valid,
   output logic [WIDTH-1:0]   out_data,
   output logic [1:0]         sel,
   output logic [3:0]         ack
);

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   state_t           state;
   logic [1:0]       ptr;
   logic [1:0]       base;
   logic [1:0]       winner;
   logic             xfer;
   logic [WIDTH-1:0] word [4];
   logic [WIDTH-1:0] word_sel;

   // Search order is base+1, base+2, base+3, base (mod 4).
   function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] b);
      logic [1:0] pick;
      logic [1:0] idx;
      logic       found;
      pick  = b;
      found = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         idx = b + 2'(k);
         if (!found && r[idx]) begin
            pick  = idx;
            found = 1'b1;
         end
      end
      return pick;
   endfunction

   always_comb begin
      for (int i = 0; i < 4; i++) begin
         word[i] = in_data[i*WIDTH +: WIDTH];
      end
   end

   assign winner   = rr_pick(req, base);
   assign word_sel = word[winner];

   // In BUSY out_valid is always 1, so a transfer is just BUSY & ready.
   // Reset suppresses the ack so a dropped word is never acknowledged.
   assign xfer = (state == BUSY) && out_valid && out_ready && !rst;

   always_comb begin
      ack = 4'b0000;
      if (xfer) begin
         ack[sel] = 1'b1;
      end
   end

`ifdef ARB_LOCK_EN
   localparam int CNT_W = (MAX_LOCK < 1) ? 1 : $clog2(MAX_LOCK + 1);
   localparam logic [CNT_W-1:0] MAXC = CNT_W'(MAX_LOCK);

   logic [CNT_W-1:0] lock_cnt;
   logic [CNT_W-1:0] cnt_next;
   logic [1:0]       last_sel;
   logic             hold;
   logic             keep;

   // lock_cnt is nonzero only while a lock run is in progress; a transfer
   // by any other requester starts a fresh run at 1.
   always_comb begin
      cnt_next = CNT_W'(1);
      if ((lock_cnt != '0) && (sel == last_sel)) begin
         cnt_next = (lock_cnt == MAXC) ? lock_cnt : lock_cnt + CNT_W'(1);
      end
      keep = lock[sel] && (cnt_next < MAXC);
   end

   // While holding, the next search starts at sel itself; ptr is untouched.
   assign base = hold ? (sel - 2'd1) : ptr;
`else
   logic unused_max_lock;
   assign unused_max_lock = (MAX_LOCK != 0);
   assign base = ptr;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         out_valid <= 1'b0;
         out_data  <= '0;
         sel       <= 2'd0;
         ptr       <= 2'd3;
`ifdef ARB_LOCK_EN
         lock_cnt  <= '0;
         last_sel  <= 2'd0;
         hold      <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (|req) begin
                  sel       <= winner;
                  out_data  <= word_sel;
                  out_valid <= 1'b1;
                  state     <= BUSY;
               end
            end
            BUSY: begin
               // Without ready, out_data/sel/out_valid simply hold.
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= IDLE;
`ifdef ARB_LOCK_EN
                  last_sel  <= sel;
                  if (keep) begin
                     hold     <= 1'b1;
                     lock_cnt <= cnt_next;
                  end else begin
                     hold     <= 1'b0;
                     ptr      <= sel;
                     lock_cnt <= '0;
                  end
`else
                  ptr       <= sel;
`endif
               end
            end
            default: begin
               state     <= IDLE;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// ----------------------------------------------------------------------------
// tb_mux4_rr_arbiter
//
// Directed bench for mux4_rr_arbiter: reset state, single grant, full
// rotation, backpressure, reset during BUSY and the lock/no-lock grant order.
// Honours ARB_LOCK_EN the same way as the design.
// ----------------------------------------------------------------------------
module tb_mux4_rr_arbiter;

   logic        clk;
   logic        rst;
   logic [3:0]  req;
   logic [31:0] in_data;
`ifdef ARB_LOCK_EN
   logic [3:0]  lock;
`endif
   logic        out_ready;
   logic        out_valid;
   logic [7:0]  out_data;
   logic [1:0]  sel;
   logic [3:0]  ack;

   int n_cmp;
   int n_bad;

   mux4_rr_arbiter #(
      .WIDTH    (8),
      .MAX_LOCK (4)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .in_data   (in_data),
`ifdef ARB_LOCK_EN
      .lock      (lock),
`endif
      .out_ready (out_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .sel       (sel),
      .ack       (ack)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_words(input logic [7:0] w0, input logic [7:0] w1,
                            input logic [7:0] w2, input logic [7:0] w3);
      in_data = {w3, w2, w1, w0};
   endtask

   task automatic do_reset();
      rst       = 1'b1;
      req       = 4'b0000;
      out_ready = 1'b0;
      step();
      rst       = 1'b0;
   endtask

   task automatic test_reset();
      rst       = 1'b1;
      req       = 4'b1111;
      out_ready = 1'b1;
      set_words(8'h11, 8'h22, 8'h33, 8'h44);
      for (int c = 0; c < 2; c++) begin
         step();
         n_cmp++;
         if (out_valid !== 1'b0) begin
            n_bad++; $display("FAIL reset_valid c%0d: got %b want 0", c, out_valid);
         end
         n_cmp++;
         if (out_data !== 8'h00) begin
            n_bad++; $display("FAIL reset_data c%0d: got %h want 00", c, out_data);
         end
         n_cmp++;
         if (sel !== 2'd0) begin
            n_bad++; $display("FAIL reset_sel c%0d: got %0d want 0", c, sel);
         end
         n_cmp++;
         if (ack !== 4'b0000) begin
            n_bad++; $display("FAIL reset_ack c%0d: got %b want 0000", c, ack);
         end
      end
   endtask

   task automatic test_single();
      do_reset();
      set_words(8'h00, 8'h00, 8'hA5, 8'h00);
      req       = 4'b0100;
      out_ready = 1'b1;
      step();
      n_cmp++;
      if (out_valid !== 1'b1) begin
         n_bad++; $display("FAIL single_valid: got %b want 1", out_valid);
      end
      n_cmp++;
      if (sel !== 2'd2) begin
         n_bad++; $display("FAIL single_sel: got %0d want 2", sel);
      end
      n_cmp++;
      if (out_data !== 8'hA5) begin
         n_bad++; $display("FAIL single_data: got %h want a5", out_data);
      end
      n_cmp++;
      if (ack !== 4'b0100) begin
         n_bad++; $display("FAIL single_ack: got %b want 0100", ack);
      end
      step();
      req = 4'b0000;
      #1;
      n_cmp++;
      if (out_valid !== 1'b0) begin
         n_bad++; $display("FAIL single_bubble_valid: got %b want 0", out_valid);
      end
      n_cmp++;
      if (ack !== 4'b0000) begin
         n_bad++; $display("FAIL single_bubble_ack: got %b want 0000", ack);
      end
   endtask

   task automatic test_rotation();
      logic [3:0] exp_ack [5];
      logic [7:0] exp_dat [5];
      exp_ack = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      exp_dat = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10};
      do_reset();
      set_words(8'h10, 8'h11, 8'h12, 8'h13);
      req       = 4'b1111;
      out_ready = 1'b1;
      for (int t = 0; t < 5; t++) begin
         step();
         n_cmp++;
         if (ack !== exp_ack[t] || out_valid !== 1'b1) begin
            n_bad++; $display("FAIL rot_ack t%0d: got ack=%b valid=%b want ack=%b valid=1",
                              t, ack, out_valid, exp_ack[t]);
         end
         n_cmp++;
         if (out_data !== exp_dat[t]) begin
            n_bad++; $display("FAIL rot_data t%0d: got %h want %h", t, out_data, exp_dat[t]);
         end
         step();
         n_cmp++;
         if (out_valid !== 1'b0 || ack !== 4'b0000) begin
            n_bad++; $display("FAIL rot_bubble t%0d: got valid=%b ack=%b want valid=0 ack=0000",
                              t, out_valid, ack);
         end
      end
   endtask

   task automatic test_backpressure();
      int acks;
      do_reset();
      set_words(8'h5A, 8'h00, 8'h00, 8'h00);
      req       = 4'b0001;
      out_ready = 1'b0;
      step();
      // Source may change its word after the capture edge.
      set_words(8'h00, 8'h00, 8'h00, 8'h00);
      for (int c = 0; c < 5; c++) begin
         n_cmp++;
         if (out_valid !== 1'b1 || out_data !== 8'h5A || ack !== 4'b0000) begin
            n_bad++; $display("FAIL bp_hold c%0d: got valid=%b data=%h ack=%b want 1/5a/0000",
                              c, out_valid, out_data, ack);
         end
         if (c < 4) step();
      end
      out_ready = 1'b1;
      #1;
      acks = 0;
      n_cmp++;
      if (ack !== 4'b0001) begin
         n_bad++; $display("FAIL bp_ack: got %b want 0001", ack);
      end
      if (ack == 4'b0001) acks++;
      step();
      req = 4'b0000;
      #1;
      if (ack != 4'b0000) acks++;
      step();
      if (ack != 4'b0000) acks++;
      n_cmp++;
      if (acks !== 1) begin
         n_bad++; $display("FAIL bp_ack_count: got %0d want 1", acks);
      end
   endtask

   task automatic test_reset_busy();
      do_reset();
      set_words(8'h77, 8'h88, 8'h99, 8'hAA);
      req       = 4'b0100;
      out_ready = 1'b0;
      step();
      n_cmp++;
      if (sel !== 2'd2 || out_valid !== 1'b1) begin
         n_bad++; $display("FAIL rb_busy: got sel=%0d valid=%b want sel=2 valid=1", sel, out_valid);
      end
      rst       = 1'b1;
      req       = 4'b1111;
      out_ready = 1'b1;
      #1;
      n_cmp++;
      if (ack !== 4'b0000) begin
         n_bad++; $display("FAIL rb_ack_gated: got %b want 0000", ack);
      end
      step();
      n_cmp++;
      if (out_valid !== 1'b0 || sel !== 2'd0) begin
         n_bad++; $display("FAIL rb_after: got valid=%b sel=%0d want valid=0 sel=0", out_valid, sel);
      end
      rst = 1'b0;
      step();
      n_cmp++;
      if (sel !== 2'd0 || out_data !== 8'h77 || out_valid !== 1'b1) begin
         n_bad++; $display("FAIL rb_regrant: got sel=%0d data=%h valid=%b want 0/77/1",
                           sel, out_data, out_valid);
      end
   endtask

   task automatic test_lock_order();
      int exp_g [8];
      int n_g;
`ifdef ARB_LOCK_EN
      exp_g = '{0, 1, 1, 1, 1, 2, 3, 0};
      n_g   = 8;
      lock  = 4'b0010;
`else
      exp_g = '{0, 1, 2, 3, 0, 0, 0, 0};
      n_g   = 5;
`endif
      do_reset();
      set_words(8'h10, 8'h11, 8'h12, 8'h13);
      req       = 4'b1111;
      out_ready = 1'b1;
      for (int g = 0; g < n_g; g++) begin
         step();
         n_cmp++;
         if (sel !== 2'(exp_g[g]) || ack !== (4'b0001 << exp_g[g])) begin
            n_bad++; $display("FAIL lock_grant g%0d: got sel=%0d ack=%b want sel=%0d",
                              g, sel, ack, exp_g[g]);
         end
         n_cmp++;
         if (out_data !== 8'(8'h10 + exp_g[g])) begin
            n_bad++; $display("FAIL lock_data g%0d: got %h want %h",
                              g, out_data, 8'(8'h10 + exp_g[g]));
         end
         step();
      end
`ifdef ARB_LOCK_EN
      lock = 4'b0000;
`endif
   endtask

   initial begin
      n_cmp     = 0;
      n_bad     = 0;
      rst       = 1'b1;
      req       = 4'b0000;
      in_data   = '0;
      out_ready = 1'b0;
`ifdef ARB_LOCK_EN
      lock      = 4'b0000;
`endif
      test_reset();
      test_single();
      test_rotation();
      test_backpressure();
      test_reset_busy();
      test_lock_order();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
